// File: rtl/rental_session_arbiter.sv
// -----------------------------------------------------------------------------
// rental_session_arbiter
// Shares one rental station between two clients and sequences each session:
// arbitrate, wait for a duration button, count down in minutes, release.
//
// Ports
//   Clk           in   system clock, rising edge
//   ResetN        in   asynchronous active-low reset
//   ClientA/B     in   level requests from the two clients
//   Button30Min   in   duration select 30 min  (lowest priority)
//   Button1Hour   in   duration select 60 min
//   Button2Hours  in   duration select 120 min (highest priority)
//   Tick          in   one-cycle pulse, one per minute
//   GrantA/B      out  station owner (never both high)
//   Busy          out  GrantA | GrantB (high in SELECT and RUN)
//   Remaining     out  minutes left in the running session
//   Code          out  {client, dur, seq}; held until the next load
//   CodeValid     out  one-cycle strobe when Code is loaded
//   Done          out  one-cycle strobe at session end
// All outputs are registered.
// -----------------------------------------------------------------------------
module rental_session_arbiter #(
    parameter int MIN_W       = 7,
    parameter int SEL_TIMEOUT = 15
) (
    input  logic             Clk,
    input  logic             ResetN,
    input  logic             ClientA,
    input  logic             ClientB,
    input  logic             Button30Min,
    input  logic             Button1Hour,
    input  logic             Button2Hours,
    input  logic             Tick,
    output logic             GrantA,
    output logic             GrantB,
    output logic             Busy,
    output logic [MIN_W-1:0] Remaining,
    output logic [5:0]       Code,
    output logic             CodeValid,
    output logic             Done
);

    localparam int CNT_W = $clog2(SEL_TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SELECT = 2'd1,
        S_RUN    = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t             state_q;
    logic               last_grant_q;   // 0 = A, 1 = B
    logic               owner_q;        // client holding the current grant
    logic [2:0]         seq_q;
    logic [CNT_W-1:0]   sel_cnt_q;
    logic               grant_a_q;
    logic               grant_b_q;
    logic               busy_q;
    logic [MIN_W-1:0]   remaining_q;
    logic [5:0]         code_q;
    logic               code_valid_q;
    logic               done_q;

    logic               btn_any_d;
    logic [1:0]         dur_d;
    logic [MIN_W-1:0]   load_d;
    logic               win_d;          // arbitration winner, 0 = A, 1 = B
    logic               owner_req_d;

    // Button priority decode and round-robin arbitration
    always_comb begin
        btn_any_d = Button2Hours | Button1Hour | Button30Min;
        if (Button2Hours) begin
            dur_d  = 2'b11;
            load_d = MIN_W'(8'd120);
        end else if (Button1Hour) begin
            dur_d  = 2'b10;
            load_d = MIN_W'(8'd60);
        end else if (Button30Min) begin
            dur_d  = 2'b01;
            load_d = MIN_W'(8'd30);
        end else begin
            dur_d  = 2'b00;
            load_d = {MIN_W{1'b0}};
        end

        // On a tie the client that did not hold the station last wins.
        if (ClientA && ClientB) begin
            win_d = ~last_grant_q;
        end else if (ClientA) begin
            win_d = 1'b0;
        end else begin
            win_d = 1'b1;
        end

        owner_req_d = owner_q ? ClientB : ClientA;
    end

    // Session FSM with registered outputs
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            seq_q        <= 3'd0;
            sel_cnt_q    <= {CNT_W{1'b0}};
            grant_a_q    <= 1'b0;
            grant_b_q    <= 1'b0;
            busy_q       <= 1'b0;
            remaining_q  <= {MIN_W{1'b0}};
            code_q       <= 6'd0;
            code_valid_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            code_valid_q <= 1'b0;
            done_q       <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (ClientA || ClientB) begin
                        owner_q   <= win_d;
                        grant_a_q <= ~win_d;
                        grant_b_q <= win_d;
                        busy_q    <= 1'b1;
                        sel_cnt_q <= {CNT_W{1'b0}};
                        state_q   <= S_SELECT;
                    end else begin
                        state_q   <= S_IDLE;
                    end
                end
                S_SELECT: begin
                    // A button beats a coincident Tick: the Tick is dropped.
                    if (btn_any_d) begin
                        remaining_q  <= load_d;
                        code_q       <= {owner_q, dur_d, seq_q};
                        code_valid_q <= 1'b1;
                        state_q      <= S_RUN;
                    end else if (!owner_req_d) begin
                        // Client walked away: release without touching fairness.
                        grant_a_q <= 1'b0;
                        grant_b_q <= 1'b0;
                        busy_q    <= 1'b0;
                        state_q   <= S_IDLE;
                    end else if (Tick) begin
                        if (sel_cnt_q == CNT_W'(SEL_TIMEOUT - 1)) begin
                            // Timed out: counts as a turn for round-robin.
                            grant_a_q    <= 1'b0;
                            grant_b_q    <= 1'b0;
                            busy_q       <= 1'b0;
                            last_grant_q <= owner_q;
                            state_q      <= S_IDLE;
                        end else begin
                            sel_cnt_q <= sel_cnt_q + CNT_W'(1'b1);
                        end
                    end else begin
                        state_q <= S_SELECT;
                    end
                end
                S_RUN: begin
                    // Buttons and requests are ignored; sessions cannot abort.
                    if (Tick) begin
                        if (remaining_q <= MIN_W'(1'b1)) begin
                            remaining_q <= {MIN_W{1'b0}};
                            grant_a_q   <= 1'b0;
                            grant_b_q   <= 1'b0;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                            state_q     <= S_DONE;
                        end else begin
                            remaining_q <= remaining_q - MIN_W'(1'b1);
                        end
                    end else begin
                        state_q <= S_RUN;
                    end
                end
                S_DONE: begin
                    last_grant_q <= owner_q;
                    seq_q        <= seq_q + 3'd1;
                    state_q      <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign GrantA    = grant_a_q;
    assign GrantB    = grant_b_q;
    assign Busy      = busy_q;
    assign Remaining = remaining_q;
    assign Code      = code_q;
    assign CodeValid = code_valid_q;
    assign Done      = done_q;

endmodule

// File: tb/tb_rental_session_arbiter.sv
// -----------------------------------------------------------------------------
// Scoreboard bench for rental_session_arbiter. Stimulus pushes the expected
// Code/Remaining of each session load and the number of expected Done strobes;
// a negedge monitor pops and compares whenever the DUT strobes an output.
// -----------------------------------------------------------------------------
module tb_rental_session_arbiter;

    logic       Clk = 1'b0;
    logic       ResetN = 1'b0;
    logic       ClientA = 1'b0;
    logic       ClientB = 1'b0;
    logic       Button30Min = 1'b0;
    logic       Button1Hour = 1'b0;
    logic       Button2Hours = 1'b0;
    logic       Tick = 1'b0;
    logic       GrantA;
    logic       GrantB;
    logic       Busy;
    logic [6:0] Remaining;
    logic [5:0] Code;
    logic       CodeValid;
    logic       Done;

    int         n_vec = 0;
    int         n_fail = 0;
    logic [5:0] exp_code_q[$];
    int         exp_rem_q[$];
    int         exp_done = 0;

    rental_session_arbiter #(.MIN_W(7), .SEL_TIMEOUT(15)) dut (
        .Clk(Clk), .ResetN(ResetN), .ClientA(ClientA), .ClientB(ClientB),
        .Button30Min(Button30Min), .Button1Hour(Button1Hour),
        .Button2Hours(Button2Hours), .Tick(Tick),
        .GrantA(GrantA), .GrantB(GrantB), .Busy(Busy), .Remaining(Remaining),
        .Code(Code), .CodeValid(CodeValid), .Done(Done)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            Tick = 1'b1;
            cyc(1);
            Tick = 1'b0;
            cyc(1);
        end
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, {13'd0, GrantA, GrantB, Busy, CodeValid, Done, Remaining, Code}, 32'd0);
    endtask

    // Full session: grant, duration button, count down to Done.
    task automatic session(input logic cl, input int btn, input int mins, input logic [2:0] seq);
        logic [1:0] dur;
        dur = (btn == 2) ? 2'b11 : (btn == 1) ? 2'b10 : 2'b01;
        chk("idle_no_grant", {30'd0, GrantA, GrantB}, 32'd0);
        cyc(1);
        chk("grant_a", {31'd0, GrantA}, {31'd0, ~cl});
        chk("grant_b", {31'd0, GrantB}, {31'd0, cl});
        exp_code_q.push_back({cl, dur, seq});
        exp_rem_q.push_back(mins);
        exp_done++;
        Button30Min  = (btn == 0);
        Button1Hour  = (btn == 1);
        Button2Hours = (btn == 2);
        cyc(1);
        Button30Min  = 1'b0;
        Button1Hour  = 1'b0;
        Button2Hours = 1'b0;
        run_ticks(mins);
    endtask

    task automatic do_reset();
        ResetN = 1'b0;
        cyc(2);
        chk_all_zero("reset_outputs");
        ResetN = 1'b1;
    endtask

    // Monitor: invariants every cycle, scoreboard pops on strobes
    always @(negedge Clk) begin
        chk("grant_exclusive", {31'd0, GrantA & GrantB}, 32'd0);
        chk("busy_eq_grant", {31'd0, Busy}, {31'd0, GrantA | GrantB});
        if (CodeValid === 1'b1) begin
            if (exp_code_q.size() == 0) begin
                chk("unexpected_codevalid", {31'd0, CodeValid}, 32'd0);
            end else begin
                chk("code", {26'd0, Code}, {26'd0, exp_code_q.pop_front()});
                chk("remaining_load", {25'd0, Remaining}, exp_rem_q.pop_front());
            end
        end
        if (Done === 1'b1) begin
            if (exp_done == 0) begin
                chk("unexpected_done", {31'd0, Done}, 32'd0);
            end else begin
                exp_done--;
                chk("done_grants", {29'd0, GrantA, GrantB, Busy}, 32'd0);
                chk("done_remaining", {25'd0, Remaining}, 32'd0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        cyc(2);
        do_reset();

        // Single 1-hour session for A.
        ClientA = 1'b1;
        session(1'b0, 1, 60, 3'd0);
        ClientA = 1'b0;

        // Round-robin over three 30-minute sessions, both clients requesting.
        do_reset();
        ClientA = 1'b1;
        ClientB = 1'b1;
        session(1'b0, 0, 30, 3'd0);
        session(1'b1, 0, 30, 3'd1);
        session(1'b0, 0, 30, 3'd2);

        // All buttons plus a Tick in SELECT: 2 h wins, no decrement.
        chk("idle_no_grant3", {30'd0, GrantA, GrantB}, 32'd0);
        cyc(1);
        chk("grant_b3", {31'd0, GrantB}, 32'd1);
        exp_code_q.push_back(6'b1_11_011);
        exp_rem_q.push_back(120);
        exp_done++;
        Button30Min = 1'b1; Button1Hour = 1'b1; Button2Hours = 1'b1; Tick = 1'b1;
        cyc(1);
        Button30Min = 1'b0; Button1Hour = 1'b0; Button2Hours = 1'b0; Tick = 1'b0;
        chk("rem_after_load", {25'd0, Remaining}, 32'd120);
        run_ticks(120);

        // SELECT timeout for B after 15 Ticks, no code load.
        ClientA = 1'b0;
        cyc(1);
        chk("grant_b_to", {31'd0, GrantB}, 32'd1);
        run_ticks(14);
        chk("grant_b_14", {31'd0, GrantB}, 32'd1);
        Tick = 1'b1;
        cyc(1);
        Tick = 1'b0;
        chk("timeout_drop", {29'd0, GrantA, GrantB, Busy}, 32'd0);
        chk("timeout_rem", {25'd0, Remaining}, 32'd0);

        // After B timed out, a tie goes to A; RUN ignores requests and buttons.
        ClientA = 1'b1;
        cyc(1);
        chk("grant_a_after_to", {30'd0, GrantA, GrantB}, 32'd2);
        exp_code_q.push_back(6'b0_01_100);
        exp_rem_q.push_back(30);
        exp_done++;
        Button30Min = 1'b1;
        cyc(1);
        Button30Min = 1'b0;
        ClientA = 1'b0;
        ClientB = 1'b0;
        Button2Hours = 1'b1;
        run_ticks(10);
        chk("run_rem_20", {25'd0, Remaining}, 32'd20);
        chk("run_grant_held", {30'd0, GrantA, GrantB}, 32'd2);
        run_ticks(20);
        Button2Hours = 1'b0;

        // Request dropped in SELECT: no load, fairness unchanged (last = A).
        ClientA = 1'b1;
        cyc(1);
        chk("grant_a_drop", {31'd0, GrantA}, 32'd1);
        ClientA = 1'b0;
        cyc(1);
        chk("drop_release", {29'd0, GrantA, GrantB, Busy}, 32'd0);

        // Eight sessions: Seq runs 5,6,7,0,1,2,3,4 starting with B.
        ClientA = 1'b1;
        ClientB = 1'b1;
        for (int i = 0; i < 8; i++) begin
            session((i % 2) == 0, 0, 30, 3'((5 + i) % 8));
        end

        // Reset in the middle of RUN: no Done, everything clears at once.
        cyc(1);
        chk("grant_b_rst", {31'd0, GrantB}, 32'd1);
        exp_code_q.push_back(6'b1_10_101);
        exp_rem_q.push_back(60);
        Button1Hour = 1'b1;
        cyc(1);
        Button1Hour = 1'b0;
        ClientA = 1'b0;
        ClientB = 1'b0;
        run_ticks(5);
        chk("rem_before_rst", {25'd0, Remaining}, 32'd55);
        ResetN = 1'b0;
        #1;
        chk_all_zero("async_reset");
        cyc(2);
        ResetN = 1'b1;
        cyc(3);
        chk_all_zero("post_reset_idle");

        chk("codes_pending", exp_code_q.size(), 32'd0);
        chk("dones_pending", exp_done, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
